inst_queue: RTL and testbench
=============================

INST_QUEUE -- requirements
Module: inst_queue

Interface
REQ-001 Parameter DEPTH, default 8, number of entries; SHALL be a power of two, minimum 4.
REQ-002 Parameter DW, default 64, entry width; SHALL hold {pc[63:32], inst[31:0]}.
REQ-003 Ports SHALL be, one per line:
  clk  input  1  single clock; all state updates on the rising edge.
  resetn  input  1  asynchronous, active-low reset.
  flush  input  1  discard all entries (redirect or exception).
  w_data_1  input  DW  first fetched entry {pc, inst}.
  w_data_1_ok  input  1  w_data_1 valid.
  w_data_2  input  DW  second fetched entry; pc = w_data_1 pc + 4.
  w_data_2_ok  input  1  w_data_2 valid.
  fifo_full  output  1  fewer than 2 free slots; fetch stalls.
  fifo_empty  output  1  count == 0.
  fifo_r_data_1  output  DW  oldest entry.
  fifo_r_data_1_ok  output  1  fifo_r_data_1 valid.
  fifo_r_data_2  output  DW  second-oldest entry.
  fifo_r_data_2_ok  output  1  fifo_r_data_2 valid.
  p_data_1  input  1  issue pops the oldest entry.
  p_data_2  input  1  issue also pops the second-oldest entry.

Function
REQ-004 State SHALL be head pointer, tail pointer (log2(DEPTH) bits, wrap modulo DEPTH), count (log2(DEPTH)+1 bits), and storage.
REQ-005 fifo_full SHALL equal (count > DEPTH-2), computed from registered count only; fifo_empty SHALL equal (count == 0).
REQ-006 Push count: 0 if fifo_full or flush or !w_data_1_ok; 1 if w_data_1_ok & !w_data_2_ok; 2 if both. w_data_2_ok without w_data_1_ok SHALL be ignored.
REQ-007 Accepted entries SHALL be written at tail and tail+1, in that order; tail advances by push count.
REQ-008 fifo_r_data_1_ok SHALL be (count >= 1); fifo_r_data_2_ok SHALL be (count >= 2); both combinational from registered state, zero latency.
REQ-009 fifo_r_data_1 SHALL be mem[head] and fifo_r_data_2 SHALL be mem[head+1 mod DEPTH]; each SHALL be driven 0 when its _ok is low.
REQ-010 Pop count: p_data_1 & p_data_2 -> 2; p_data_1 alone -> 1; p_data_2 alone -> 0 (ignored). Pop count SHALL be clipped to count; head advances by clipped pop count.
REQ-011 Same-cycle push and pop SHALL both take effect: count_next = count + push - pop. A just-pushed entry is not readable until the next cycle (no bypass).
REQ-012 flush SHALL have priority over push and pop: next cycle head = tail = count = 0, all _ok low; same-cycle pushes SHALL be discarded.
REQ-013 count SHALL never exceed DEPTH or underflow; guaranteed by REQ-005 and REQ-010.

Reset
REQ-014 On resetn low, asynchronously: head = tail = 0, count = 0; hence fifo_empty = 1, fifo_full = 0, both _ok = 0, both read data = 0.
REQ-015 Storage contents SHALL NOT require reset.
REQ-016 Reset asserted mid-operation SHALL discard all entries; the first cycle after release SHALL accept pushes.

Structure
REQ-017 A shared package SHALL hold the queue depth constant and the entry field positions (PC_HI = 63, PC_LO = 32, INST_HI = 31, INST_LO = 0).
REQ-018 Storage SHALL be one sub-module, inst_queue_ram: DEPTH x DW, 2 synchronous write ports, 2 asynchronous read ports; pointer and count logic stays in inst_queue.

Verification
REQ-019 After reset, push {0xBFC00000, 0x24010001} and {0xBFC00004, 0x24020002} -> next cycle count = 2, both _ok = 1, read data in push order.
REQ-020 Fill to 7 entries (DEPTH = 8) -> fifo_full = 1; a push of 2 SHALL be dropped and count stays 7. Pop 1 -> count 6, fifo_full = 0.
REQ-021 Wrap-around: 20 cycles of push 2 / pop 2 from count 2 -> pc sequence read strictly +4 increments, no loss or duplication, count constant at 2.
REQ-022 Count = 1 with p_data_1 = p_data_2 = 1 -> pop clipped to 1, count 0, fifo_empty = 1; p_data_2 alone -> no pop.
REQ-023 Count = 5 with flush, push 2 and pop 2 all asserted in one cycle -> next cycle count = 0, both _ok = 0, read data = 0.
REQ-024 Assert resetn low mid-stream at count 4 -> immediately both _ok = 0 and fifo_empty = 1; after release, the first push of 1 entry -> count 1.

Source files
------------

// File: rtl/inst_queue_pkg.sv
// inst_queue_pkg: shared depth/width constants, entry field positions and request decoding.
package inst_queue_pkg;
  localparam int IQ_DEPTH = 8;
  localparam int IQ_DW = 64;
  localparam int PC_HI = 63;
  localparam int PC_LO = 32;
  localparam int INST_HI = 31;
  localparam int INST_LO = 0;
  // A second request only counts alongside the first one.
  function automatic logic [1:0] req_cnt(input logic first, input logic second);
    return first ? (second ? 2'd2 : 2'd1) : 2'd0;
  endfunction
endpackage

// File: rtl/inst_queue_ram.sv
// inst_queue_ram: DEPTH x DW storage, two synchronous write ports and two asynchronous read ports.
module inst_queue_ram #(
  parameter int DEPTH = 8,
  parameter int DW = 64,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_1_i,
  input  logic [AW-1:0] waddr_1_i,
  input  logic [DW-1:0] wdata_1_i,
  input  logic          we_2_i,
  input  logic [AW-1:0] waddr_2_i,
  input  logic [DW-1:0] wdata_2_i,
  input  logic [AW-1:0] raddr_1_i,
  output logic [DW-1:0] rdata_1_o,
  input  logic [AW-1:0] raddr_2_i,
  output logic [DW-1:0] rdata_2_o
);
  logic [DW-1:0] mem_q [DEPTH];
  always_ff @(posedge clk) begin
    if (we_1_i) mem_q[waddr_1_i] <= wdata_1_i;
    if (we_2_i) mem_q[waddr_2_i] <= wdata_2_i;
  end
  assign rdata_1_o = mem_q[raddr_1_i];
  assign rdata_2_o = mem_q[raddr_2_i];
endmodule

// File: rtl/inst_queue.sv
// inst_queue: dual-push / dual-pop instruction FIFO between fetch and issue.
module inst_queue import inst_queue_pkg::*; #(
  parameter int DEPTH = IQ_DEPTH,
  parameter int DW = IQ_DW
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          flush,
  input  logic [DW-1:0] w_data_1,
  input  logic          w_data_1_ok,
  input  logic [DW-1:0] w_data_2,
  input  logic          w_data_2_ok,
  output logic          fifo_full,
  output logic          fifo_empty,
  output logic [DW-1:0] fifo_r_data_1,
  output logic          fifo_r_data_1_ok,
  output logic [DW-1:0] fifo_r_data_2,
  output logic          fifo_r_data_2_ok,
  input  logic          p_data_1,
  input  logic          p_data_2
);
  localparam int AW = $clog2(DEPTH);
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [AW:0] count_q, count_d;
  logic [1:0] push, pop_req, pop;
  logic [DW-1:0] rd_1, rd_2;
  assign fifo_full = count_q > (AW+1)'(DEPTH-2);
  assign fifo_empty = count_q == '0;
  assign fifo_r_data_1_ok = count_q >= (AW+1)'(1);
  assign fifo_r_data_2_ok = count_q >= (AW+1)'(2);
  assign fifo_r_data_1 = fifo_r_data_1_ok ? rd_1 : '0;
  assign fifo_r_data_2 = fifo_r_data_2_ok ? rd_2 : '0;
  // Full means fewer than two free slots, so a pair push can never overflow.
  always_comb begin
    push = (fifo_full || flush) ? 2'd0 : req_cnt(w_data_1_ok, w_data_2_ok);
    pop_req = req_cnt(p_data_1, p_data_2);
    pop = ((AW+1)'(pop_req) > count_q) ? count_q[1:0] : pop_req;
    head_d = flush ? '0 : head_q + AW'(pop);
    tail_d = flush ? '0 : tail_q + AW'(push);
    count_d = flush ? '0 : count_q + (AW+1)'(push) - (AW+1)'(pop);
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
    end
  end
  inst_queue_ram #(.DEPTH(DEPTH), .DW(DW)) u_ram (
    .clk       (clk),
    .we_1_i    (push != 2'd0),
    .waddr_1_i (tail_q),
    .wdata_1_i (w_data_1),
    .we_2_i    (push == 2'd2),
    .waddr_2_i (tail_q + AW'(1)),
    .wdata_2_i (w_data_2),
    .raddr_1_i (head_q),
    .rdata_1_o (rd_1),
    .raddr_2_i (head_q + AW'(1)),
    .rdata_2_o (rd_2)
  );
endmodule

// File: tb/tb_inst_queue.sv
// tb_inst_queue: directed and random stimulus against a queue-based reference model.
module tb_inst_queue;
  import inst_queue_pkg::*;
  localparam int DEPTH = 8;
  logic clk = 0, resetn = 0, flush = 0;
  logic [63:0] w_data_1 = '0, w_data_2 = '0;
  logic w_data_1_ok = 0, w_data_2_ok = 0, p_data_1 = 0, p_data_2 = 0;
  logic fifo_full, fifo_empty, fifo_r_data_1_ok, fifo_r_data_2_ok;
  logic [63:0] fifo_r_data_1, fifo_r_data_2;
  int checks = 0, errors = 0;
  bit rnd = 0;
  logic [31:0] next_pc = 32'hBFC00000;
  logic [63:0] q[$];
  inst_queue dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .w_data_1(w_data_1), .w_data_1_ok(w_data_1_ok),
    .w_data_2(w_data_2), .w_data_2_ok(w_data_2_ok),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .fifo_r_data_1(fifo_r_data_1), .fifo_r_data_1_ok(fifo_r_data_1_ok),
    .fifo_r_data_2(fifo_r_data_2), .fifo_r_data_2_ok(fifo_r_data_2_ok),
    .p_data_1(p_data_1), .p_data_2(p_data_2)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  // Reference: a plain queue; full is judged on the occupancy before this cycle's pops.
  always @(posedge clk or negedge resetn) begin
    if (!resetn || flush) q.delete();
    else begin
      int n;
      bit full;
      full = q.size() > DEPTH - 2;
      n = p_data_1 ? (p_data_2 ? 2 : 1) : 0;
      if (n > q.size()) n = q.size();
      repeat (n) void'(q.pop_front());
      if (!full && w_data_1_ok) begin
        q.push_back(w_data_1);
        next_pc += 32'd4;
        if (w_data_2_ok) begin
          q.push_back(w_data_2);
          next_pc += 32'd4;
        end
      end
    end
  end
  always @(negedge clk) begin
    chk("full", fifo_full, 64'(q.size() > DEPTH - 2));
    chk("empty", fifo_empty, 64'(q.size() == 0));
    chk("ok1", fifo_r_data_1_ok, 64'(q.size() >= 1));
    chk("ok2", fifo_r_data_2_ok, 64'(q.size() >= 2));
    chk("rdata1", fifo_r_data_1, q.size() >= 1 ? q[0] : 64'd0);
    chk("rdata2", fifo_r_data_2, q.size() >= 2 ? q[1] : 64'd0);
  end
  task automatic cyc(input bit f, input bit a, input bit b, input bit p1, input bit p2);
    flush = f; w_data_1_ok = a; w_data_2_ok = b; p_data_1 = p1; p_data_2 = p2;
    w_data_1 = {next_pc, rnd ? $urandom : 32'h24010001};
    w_data_2 = {next_pc + 32'd4, rnd ? $urandom : 32'h24020002};
    @(posedge clk); #1;
  endtask
  initial begin
    logic [31:0] prev_pc;
    #1;
    chk("rst_empty", fifo_empty, 1);
    chk("rst_full", fifo_full, 0);
    chk("rst_ok1", fifo_r_data_1_ok, 0);
    chk("rst_ok2", fifo_r_data_2_ok, 0);
    chk("rst_data1", fifo_r_data_1, 0);
    repeat (2) @(posedge clk);
    #1 resetn = 1;
    cyc(0, 1, 1, 0, 0);
    chk("first_d1", fifo_r_data_1, 64'hBFC00000_24010001);
    chk("first_d2", fifo_r_data_2, 64'hBFC00004_24020002);
    chk("first_ok2", fifo_r_data_2_ok, 1);
    chk("first_model", q.size(), 2);
    cyc(0, 1, 1, 0, 0);
    cyc(0, 1, 1, 0, 0);
    cyc(0, 1, 0, 0, 0);
    chk("full_at7", fifo_full, 1);
    cyc(0, 1, 1, 0, 0);
    chk("full_drop", fifo_full, 1);
    chk("full_model", q.size(), 7);
    chk("full_d1", fifo_r_data_1, 64'hBFC00000_24010001);
    cyc(0, 0, 0, 1, 0);
    chk("unfull_at6", fifo_full, 0);
    cyc(0, 0, 0, 1, 1);
    cyc(0, 0, 0, 1, 1);
    chk("drain_d1", fifo_r_data_1[PC_HI:PC_LO], 32'hBFC00014);
    prev_pc = fifo_r_data_1[PC_HI:PC_LO];
    for (int i = 0; i < 20; i++) begin
      cyc(0, 1, 1, 1, 1);
      chk("wrap_pc1", fifo_r_data_1[PC_HI:PC_LO], prev_pc + 32'd8);
      chk("wrap_pc2", fifo_r_data_2[PC_HI:PC_LO], prev_pc + 32'd12);
      chk("wrap_ok2", fifo_r_data_2_ok, 1);
      prev_pc = fifo_r_data_1[PC_HI:PC_LO];
    end
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1);
    chk("p2_alone_ok1", fifo_r_data_1_ok, 1);
    cyc(0, 0, 0, 1, 1);
    chk("clip_empty", fifo_empty, 1);
    cyc(0, 1, 1, 0, 0);
    cyc(0, 1, 1, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(1, 1, 1, 1, 1);
    chk("flush_ok1", fifo_r_data_1_ok, 0);
    chk("flush_ok2", fifo_r_data_2_ok, 0);
    chk("flush_d1", fifo_r_data_1, 0);
    chk("flush_d2", fifo_r_data_2, 0);
    chk("flush_empty", fifo_empty, 1);
    cyc(0, 1, 1, 0, 0);
    cyc(0, 1, 1, 0, 0);
    w_data_1_ok = 0; w_data_2_ok = 0;
    resetn = 0;
    #1;
    chk("arst_ok1", fifo_r_data_1_ok, 0);
    chk("arst_ok2", fifo_r_data_2_ok, 0);
    chk("arst_empty", fifo_empty, 1);
    @(posedge clk); #1 resetn = 1;
    cyc(0, 1, 0, 0, 0);
    chk("post_rst_ok1", fifo_r_data_1_ok, 1);
    chk("post_rst_ok2", fifo_r_data_2_ok, 0);
    rnd = 1;
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 39) == 0, $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
          $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1);
    cyc(0, 0, 0, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
